// File: rtl/mem_buff_arb.sv
// FIFO sequencer and round-robin arbiter sharing one mem_buff between two requesters.
// Optional sticky error flags are built when MEM_BUFF_ARB_ERR_EN is defined.
module mem_buff_arb #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PW    = 3,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rest,
  input  logic          req0_w,
  input  logic          req0_r,
  input  logic [DW-1:0] req0_data,
  input  logic          req1_w,
  input  logic          req1_r,
  input  logic [DW-1:0] req1_data,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rd_valid0,
  output logic          rd_valid1,
  output logic [DW-1:0] rd_data,
  output logic [DW-1:0] buf_data_in,
  output logic [AW-1:0] buf_address,
  output logic          buf_en_w,
  output logic          buf_en_r,
  input  logic [DW-1:0] buf_data_out,
  output logic [PW:0]   count,
  output logic          full,
  output logic          empty
`ifdef MEM_BUFF_ARB_ERR_EN
  ,
  output logic [1:0]    err
`endif
);

  typedef enum logic [1:0] {StIdle, StWrIssue, StRdIssue, StRdReturn} state_e;

  localparam logic [PW:0] FullCount = (PW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          last_gnt_q, last_gnt_d;
  logic          sel_q, sel_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic wr0, rd0, wr1, rd1;
  logic elig0, elig1, win1, win_wr, issue;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);

  // A write takes priority when a requester raises both request lines.
  assign wr0 = req0_w;
  assign rd0 = req0_r & ~req0_w;
  assign wr1 = req1_w;
  assign rd1 = req1_r & ~req1_w;

  assign elig0  = (wr0 & ~full) | (rd0 & ~empty);
  assign elig1  = (wr1 & ~full) | (rd1 & ~empty);
  // last_gnt_q = 1 means requester 1 won last, so requester 0 wins a tie.
  assign win1   = elig1 & (~elig0 | ~last_gnt_q);
  assign win_wr = win1 ? wr1 : wr0;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    last_gnt_d = last_gnt_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (elig0 | elig1) begin
          sel_d      = win1;
          last_gnt_d = win1;
          if (win_wr) begin
            state_d  = StWrIssue;
            addr_d   = AW'(wr_ptr_q);
            wdata_d  = win1 ? req1_data : req0_data;
            wr_ptr_d = wr_ptr_q + PW'(1);
            count_d  = count_q + (PW+1)'(1);
          end else begin
            state_d  = StRdIssue;
            addr_d   = AW'(rd_ptr_q);
            rd_ptr_d = rd_ptr_q + PW'(1);
            count_d  = count_q - (PW+1)'(1);
          end
        end
      end
      StWrIssue:  state_d = StIdle;
      StRdIssue:  state_d = StRdReturn;
      StRdReturn: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_gnt_q <= 1'b1;
      sel_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_gnt_q <= last_gnt_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign issue       = (state_q == StWrIssue) || (state_q == StRdIssue);
  assign gnt0        = issue & ~sel_q;
  assign gnt1        = issue & sel_q;
  assign rd_valid0   = (state_q == StRdReturn) & ~sel_q;
  assign rd_valid1   = (state_q == StRdReturn) & sel_q;
  assign buf_en_w    = (state_q == StWrIssue);
  assign buf_en_r    = (state_q == StRdIssue);
  assign buf_address = addr_q;
  assign buf_data_in = wdata_q;
  assign rd_data     = buf_data_out;
  assign count       = count_q;

`ifdef MEM_BUFF_ARB_ERR_EN
  logic [1:0] err_q, err_d;

  // Sticky: flags requests that IDLE saw but could never be served at that moment.
  always_comb begin
    err_d = err_q;
    if (state_q == StIdle) begin
      if ((wr0 | wr1) & full)  err_d[0] = 1'b1;
      if ((rd0 | rd1) & empty) err_d[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_mem_buff_arb.sv
// Bench for mem_buff_arb: directed and random traffic against a queue-based FIFO/arbiter
// model, with a decoupled scoreboard monitor. Honours MEM_BUFF_ARB_ERR_EN when defined.
module tb_mem_buff_arb;

  logic       clk = 1'b0;
  logic       rest = 1'b1;
  logic       req0_w = 1'b0, req0_r = 1'b0, req1_w = 1'b0, req1_r = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       gnt0, gnt1, rd_valid0, rd_valid1, buf_en_w, buf_en_r, full, empty;
  logic [7:0] rd_data, buf_data_in, buf_data_out;
  logic [3:0] buf_address;
  logic [3:0] count;
`ifdef MEM_BUFF_ARB_ERR_EN
  logic [1:0] err;
`endif

  always #5 clk = ~clk;

  mem_buff_arb dut (
    .clk          (clk),
    .rest         (rest),
    .req0_w       (req0_w),
    .req0_r       (req0_r),
    .req0_data    (req0_data),
    .req1_w       (req1_w),
    .req1_r       (req1_r),
    .req1_data    (req1_data),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .rd_valid0    (rd_valid0),
    .rd_valid1    (rd_valid1),
    .rd_data      (rd_data),
    .buf_data_in  (buf_data_in),
    .buf_address  (buf_address),
    .buf_en_w     (buf_en_w),
    .buf_en_r     (buf_en_r),
    .buf_data_out (buf_data_out),
    .count        (count),
    .full         (full),
    .empty        (empty)
`ifdef MEM_BUFF_ARB_ERR_EN
    ,
    .err          (err)
`endif
  );

  // Simple stand-in for mem_buff: synchronous write, registered read.
  logic [7:0] mem [16];
  always @(posedge clk or negedge rest) begin
    if (!rest) begin
      buf_data_out <= '0;
    end else begin
      if (buf_en_w) mem[buf_address] <= buf_data_in;
      if (buf_en_r) buf_data_out <= mem[buf_address];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; bit who; bit wr; logic [3:0] addr; logic [7:0] data; } gnt_t;
  typedef struct { int cyc; bit who; logic [7:0] data; } rdv_t;
  typedef struct { int cnt; logic [1:0] err; } st_t;

  gnt_t gq[$];
  rdv_t rq[$];
  st_t  sq[$];

  int checks = 0;
  int errors = 0;
  int stall = 0;
  int stall_seen = 0;
  bit done = 1'b0;
  bit final_done = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Scoreboard monitor: samples 1 time unit after each rising edge or reset assertion.
  always begin
    gnt_t g;
    rdv_t r;
    st_t  s;
    @(posedge clk or negedge rest);
    #1;
    if (!rest) begin
      chk("reset_outputs",
          {gnt0, gnt1, rd_valid0, rd_valid1, buf_en_w, buf_en_r, full, empty,
           count, buf_address, buf_data_in, rd_data}, 32'h0100_0000);
`ifdef MEM_BUFF_ARB_ERR_EN
      chk("reset_err", 32'(err), 32'd0);
`endif
    end else begin
      if (sq.size() > 0) begin
        s = sq.pop_front();
        chk("count", 32'(count), 32'(s.cnt));
        chk("full", 32'(full), 32'(s.cnt == 8));
        chk("empty", 32'(empty), 32'(s.cnt == 0));
`ifdef MEM_BUFF_ARB_ERR_EN
        chk("err", 32'(err), 32'(s.err));
`endif
      end
      chk("en_exclusive", 32'(buf_en_w & buf_en_r), 32'd0);
      if (gnt0 | gnt1) begin
        chk("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
        if (gq.size() == 0) begin
          chk("gnt_unexpected", 32'(gnt1), 32'(!gnt1));
        end else begin
          g = gq.pop_front();
          chk("gnt_cycle", 32'(cyc), 32'(g.cyc));
          chk("gnt_who", 32'(gnt1), 32'(g.who));
          chk("gnt_en_w", 32'(buf_en_w), 32'(g.wr));
          chk("gnt_en_r", 32'(buf_en_r), 32'(!g.wr));
          chk("gnt_address", 32'(buf_address), 32'(g.addr));
          if (g.wr) chk("gnt_wdata", 32'(buf_data_in), 32'(g.data));
        end
      end else begin
        chk("en_without_gnt", 32'(buf_en_w | buf_en_r), 32'd0);
        if (gq.size() > 0 && gq[0].cyc < cyc) begin
          g = gq.pop_front();
          chk("gnt_missing", 32'(cyc), 32'(g.cyc));
        end
      end
      if (rd_valid0 | rd_valid1) begin
        chk("rdv_onehot", 32'(rd_valid0 & rd_valid1), 32'd0);
        if (rq.size() == 0) begin
          chk("rdv_unexpected", 32'(rd_valid1), 32'(!rd_valid1));
        end else begin
          r = rq.pop_front();
          chk("rdv_cycle", 32'(cyc), 32'(r.cyc));
          chk("rdv_who", 32'(rd_valid1), 32'(r.who));
          chk("rdv_data", 32'(rd_data), 32'(r.data));
        end
      end else if (rq.size() > 0 && rq[0].cyc < cyc) begin
        r = rq.pop_front();
        chk("rdv_missing", 32'(cyc), 32'(r.cyc));
      end
    end
    if (stall != stall_seen) begin
      chk("wait_bound", 32'(stall), 32'(stall_seen));
      stall_seen = stall;
    end
    if (done && !final_done) begin
      chk("drain_gnt", 32'(gq.size()), 32'd0);
      chk("drain_rdv", 32'(rq.size()), 32'd0);
      final_done = 1'b1;
    end
  end

  // Requester slots: 0 none, 1 write, 2 read, 3 write+read (acts as write).
  int         op[2];
  logic [7:0] dat[2];
  int         rep[2];
  bit         auto_mode = 1'b0;

  // Reference model: FIFO contents as a queue, pointers as plain modulo counters.
  logic [7:0] fifo[$];
  int         wp, rp, busy;
  bit         last;
  logic [1:0] merr;

  function automatic int rand_op();
    int r = int'($urandom_range(99));
    if (r < 20) return 0;
    if (r < 55) return 1;
    if (r < 90) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    fifo.delete();
    gq.delete();
    rq.delete();
    sq.delete();
    wp = 0;
    rp = 0;
    busy = 0;
    last = 1'b1;
    merr = '0;
  endtask

  task automatic drive();
    req0_w = (op[0] == 1) || (op[0] == 3);
    req0_r = (op[0] == 2) || (op[0] == 3);
    req1_w = (op[1] == 1) || (op[1] == 3);
    req1_r = (op[1] == 2) || (op[1] == 3);
    req0_data = dat[0];
    req1_data = dat[1];
  endtask

  // One negedge: requester reactions, new input values, and model prediction.
  task automatic step();
    bit gv[2];
    bit wr[2], rd[2], el[2];
    bit w;
    gv[0] = gnt0;
    gv[1] = gnt1;
    for (int i = 0; i < 2; i++) begin
      if (gv[i]) begin
        if (rep[i] > 0) begin
          rep[i]--;
          dat[i] = dat[i] + 8'd1;
        end else if (auto_mode) begin
          op[i] = rand_op();
          dat[i] = 8'($urandom);
        end else begin
          op[i] = 0;
        end
      end else if (auto_mode && ($urandom_range(99) < ((op[i] == 0) ? 40 : 4))) begin
        op[i] = rand_op();
        dat[i] = 8'($urandom);
      end
    end
    drive();
    if (busy > 0) begin
      busy--;
    end else begin
      for (int i = 0; i < 2; i++) begin
        wr[i] = (op[i] == 1) || (op[i] == 3);
        rd[i] = (op[i] == 2);
        el[i] = (wr[i] && fifo.size() < 8) || (rd[i] && fifo.size() > 0);
      end
      if ((wr[0] || wr[1]) && fifo.size() == 8) merr[0] = 1'b1;
      if ((rd[0] || rd[1]) && fifo.size() == 0) merr[1] = 1'b1;
      if (el[0] || el[1]) begin
        w = (el[0] && el[1]) ? !last : el[1];
        last = w;
        if (wr[w]) begin
          gq.push_back('{cyc + 1, w, 1'b1, 4'(wp), dat[w]});
          fifo.push_back(dat[w]);
          wp = (wp + 1) % 8;
          busy = 1;
        end else begin
          gq.push_back('{cyc + 1, w, 1'b0, 4'(rp), 8'd0});
          rq.push_back('{cyc + 2, w, fifo.pop_front()});
          rp = (rp + 1) % 8;
          busy = 2;
        end
      end
    end
    sq.push_back('{fifo.size(), merr});
  endtask

  task automatic tick();
    @(negedge clk);
    step();
  endtask

  task automatic wait_slots();
    int n = 0;
    while ((op[0] != 0 || op[1] != 0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) stall++;
    repeat (4) tick();
  endtask

  task automatic reset_assert();
    rest = 1'b0;
    for (int i = 0; i < 2; i++) begin
      op[i] = 0;
      rep[i] = 0;
      dat[i] = '0;
    end
    drive();
    model_reset();
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    reset_assert();
    repeat (2) @(negedge clk);
    rest = 1'b1;
    step();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      op[i] = 0;
      rep[i] = 0;
      dat[i] = '0;
    end
    #2;
    reset_assert();
    repeat (2) @(negedge clk);
    rest = 1'b1;
    step();

    // First write after reset.
    op[0] = 1;
    dat[0] = 8'h11;
    wait_slots();

    // Both requesters writing together alternate, requester 0 first.
    reset_cycle();
    op[0] = 1; dat[0] = 8'h20; rep[0] = 1;
    op[1] = 1; dat[1] = 8'h30; rep[1] = 1;
    wait_slots();

    // Fill, hold a write while full, then free one entry and see the wrap.
    reset_cycle();
    op[0] = 1; dat[0] = 8'h01; rep[0] = 7;
    wait_slots();
    op[1] = 1; dat[1] = 8'hAA;
    repeat (10) tick();
    op[0] = 2;
    wait_slots();

    // Drain everything, then read from an empty buffer.
    op[0] = 2; rep[0] = 7;
    wait_slots();
    op[0] = 2;
    repeat (8) tick();
    op[0] = 0;
    repeat (4) tick();

    // Reset in the middle of a read issue.
    op[0] = 1; dat[0] = 8'h55;
    wait_slots();
    op[0] = 2;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(gnt0 && buf_en_r) && n < 50);
    if (n >= 50) stall++;
    reset_assert();
    repeat (2) @(negedge clk);
    rest = 1'b1;
    step();
    op[1] = 1; dat[1] = 8'h77;
    wait_slots();

    // Random traffic.
    auto_mode = 1'b1;
    repeat (3000) tick();
    auto_mode = 1'b0;
    op[0] = 0;
    op[1] = 0;
    rep[0] = 0;
    rep[1] = 0;
    repeat (6) tick();
    done = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
